// File: rtl/unsigned_trunc_mul_pipe.sv
// Purpose: pipelined unsigned multiplier with per-beat exact/approximate mode
//          (low x-rows column-truncated at weight K) and a saturating error monitor.
// Latency: 2 cycles input-accept to output-valid; 1 beat/cycle with out_ready held high.
// Backpressure: in_ready = !out_valid | out_ready; when low the whole pipe holds, bubbles included.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; x, y operands, approx selects mode per beat
//   out_valid/out_ready result handshake; z product, z_approx mode tag
//   clr_stats           synchronous clear of err_acc/op_cnt (wins over same-cycle update)
//   err_acc, op_cnt     saturating sum of (exact - z) and count over transferred approx beats
module unsigned_trunc_mul_pipe #(
  parameter int W     = 8,
  parameter int L     = 4,
  parameter int K     = 7,
  parameter int ERR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  input  logic              approx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    z,
  output logic              z_approx,
  input  logic              clr_stats,
  output logic [ERR_W-1:0]  err_acc,
  output logic [ERR_W-1:0]  op_cnt
);

  localparam int PW = 2 * W;
  // Accumulator sum is wide enough to hold either operand plus a carry.
  localparam int SW = ((ERR_W > PW) ? ERR_W : PW) + 1;

  localparam logic [PW-1:0] ONE_P   = 1;
  // Keeps partial-product bits of weight >= K.
  localparam logic [PW-1:0] KEEP    = ~((ONE_P << K) - ONE_P);
  localparam logic [SW-1:0] ONE_S   = 1;
  localparam logic [SW-1:0] ACC_MAX = (ONE_S << ERR_W) - ONE_S;

  logic          adv;
  logic [PW-1:0] hi, lo_ap, lo_ex, row;

  logic          s1_vld;
  logic [PW-1:0] s1_hi, s1_lo_ap, s1_lo_ex;
  logic          s1_approx;
  logic [PW-1:0] s2_err;

  logic          stat_upd;
  logic [SW-1:0] acc_sum;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !rst && adv;

  // Row-by-row partial products. Rows below L feed both the exact and the
  // truncated low sums; the difference of those two is exactly the error.
  always_comb begin
    hi    = '0;
    lo_ap = '0;
    lo_ex = '0;
    row   = '0;
    for (int i = 0; i < W; i++) begin
      row = PW'(y) << i;
      if (x[i]) begin
        if (i >= L) begin
          hi = hi + row;
        end else begin
          lo_ex = lo_ex + row;
          lo_ap = lo_ap + (row & KEEP);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_hi     <= '0;
      s1_lo_ap  <= '0;
      s1_lo_ex  <= '0;
      s1_approx <= 1'b0;
      out_valid <= 1'b0;
      z         <= '0;
      z_approx  <= 1'b0;
      s2_err    <= '0;
    end else if (adv) begin
      s1_vld    <= in_valid;
      if (in_valid) begin
        s1_hi     <= hi;
        s1_lo_ap  <= lo_ap;
        s1_lo_ex  <= lo_ex;
        s1_approx <= approx;
      end
      out_valid <= s1_vld;
      // Bubbles leave z untouched so the last result stays visible.
      if (s1_vld) begin
        z        <= s1_hi + (s1_approx ? s1_lo_ap : s1_lo_ex);
        z_approx <= s1_approx;
        s2_err   <= s1_approx ? (s1_lo_ex - s1_lo_ap) : '0;
      end
    end
  end

  assign stat_upd = out_valid && out_ready && z_approx;
  assign acc_sum  = SW'(err_acc) + SW'(s2_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_acc <= '0;
      op_cnt  <= '0;
    end else if (clr_stats) begin
      err_acc <= '0;
      op_cnt  <= '0;
    end else if (stat_upd) begin
      if (acc_sum > ACC_MAX) err_acc <= '1;
      else                   err_acc <= acc_sum[ERR_W-1:0];
      if (op_cnt != '1) op_cnt <= op_cnt + ERR_W'(1);
    end
  end

endmodule
